color_calib: RTL and testbench
==============================

# color_calib

Runtime calibration source for the two-class HSV colour classifier: the block accumulates statistics of the RGB pixels inside a fixed square region of interest (ROI) of one frame. From them it produces the reference parameter set (R0, G0, B0, err, Vmin, Vmax) that the classifier consumes on its `i_a_*` / `i_b_*` inputs. It sits beside the classifier on the same pixel stream. Software or a push-button pulses `i_start`, and one calibration result is written per request.

## Interface
Parameters:
- C_W, `COLOR_WIDTH: width of each colour channel.
- H_ACT, 640: active pixels per line; the x counter wraps here.
- ROI_X, 312: left column of the ROI.
- ROI_Y, 232: top line of the ROI.
- ROI_LOG2, 4: ROI side is 2^ROI_LOG2 pixels (16×16, 256 pixels).
- ERR_MARGIN, 4: added to the measured spread to form err.
- V_MARGIN, 8: widens Vmin downward and Vmax upward.

Ports:
- sys_clk, in, 1: clock.
- sys_rst_n, in, 1: asynchronous, active-low reset.
- i_start, in, 1: calibration request pulse.
- i_vs, in, 1: frame-start pulse; clears the x/y counters.
- i_valid, in, 1: pixel qualifier.
- i_R / i_G / i_B, in, C_W each: pixel channels.
- o_busy, out, 1: high while a calibration is in progress.
- o_done, out, 1: one-cycle pulse; a new parameter set is valid.
- o_cal_ok, out, 1: sticky; at least one calibration has completed since reset.
- o_R0 / o_G0 / o_B0, out, C_W each: ROI channel means.
- o_err, out, C_W+2: colour tolerance.
- o_Vmin / o_Vmax, out, C_W+2: brightness window.

## Operation
- Brightness: V = R+G+B, computed at C_W+2 bits with no overflow.
- Reset values: every output is 0; the FSM is in IDLE; accumulators, min/max registers and counters are cleared.
- FSM:
  - IDLE: `i_start` moves to ARM.
  - ARM: `i_vs` moves to ACCUM.
  - ACCUM: the last ROI pixel moves to CALC.
  - CALC: moves to IDLE after one cycle.
- `i_start` is ignored outside IDLE.
- x/y counters:
  - Run in every state.
  - `i_vs` forces x=0, y=0.
  - Each `i_valid` increments x; at x=H_ACT-1, x wraps to 0 and y increments.
- A pixel is in the ROI when ROI_X ≤ x < ROI_X+2^ROI_LOG2 and ROI_Y ≤ y < ROI_Y+2^ROI_LOG2.
- In ACCUM, each ROI pixel updates:
  - the per-channel sum, C_W+2·ROI_LOG2 bits;
  - the per-channel min and max;
  - min(V) and max(V).
- Entering ACCUM clears all statistics: sums to 0, mins to all-ones, maxes to 0.
- CALC computes:
  - R0/G0/B0 = sum >> (2·ROI_LOG2), truncated.
  - err = max(Rmax−Rmin, Gmax−Gmin, Bmax−Bmin) + ERR_MARGIN, saturated at 2^(C_W+2)−1.
  - Vmin = Vmin_meas − V_MARGIN, saturated at 0.
  - Vmax = Vmax_meas + V_MARGIN, saturated at 2^(C_W+2)−1.
- Outputs register at the end of CALC and hold until the next CALC.
- Boundary rules:
  - `i_vs` during ACCUM before the ROI completes: clear the statistics and stay in ACCUM, so the new frame is used.
  - `i_vs` and `i_valid` in the same cycle: the pixel is counted as (0,0) of the new frame.
  - `i_start` coincident with CALC: ignored.
  - Reset mid-calibration: return to the reset state, drop `o_cal_ok`, zero the outputs.

## Timing
- `i_start` high at cycle t in IDLE: ARM and `o_busy` are high from t+1.
- Last ROI pixel presented at cycle t: CALC during t+1.
- Parameter outputs change, `o_done`=1 and `o_cal_ok`=1 at t+2.
- `o_busy` falls at t+2.
- `o_done` is high for exactly one cycle.
- Throughput: one pixel per clock; `i_valid` may be high every cycle.

## Structure
- Shared package / define.v holds:
  - `COLOR_WIDTH`;
  - the FSM state encoding (IDLE, ARM, ACCUM, CALC);
  - the saturating add/sub width rule (C_W+2).
- One natural sub-module, `color_calib_stat`: one channel's sum/min/max with a clear and an enable. It is instantiated three times for R/G/B and once, in min/max-only form, for V.

## Test plan
- Uniform ROI R=20, G=40, B=10 (C_W=8, defaults) → R0=20, G0=40, B0=10, err=4, Vmin=62, Vmax=78, `o_done` two cycles after the last ROI pixel.
- ROI with R alternating 10/30, G=B=0 → R0=20, err=24, Vmin=2, Vmax=38.
- Black ROI (all 0) → Vmin saturates at 0. White ROI (255,255,255) → Vmax=765+8=773, below saturation at 1023; err=4.
- `i_vs` after 100 ROI pixels of frame A, then frame B uniform 50 → outputs reflect only frame B (50).
- `i_start` pulsed during ACCUM, and again in the `o_done` cycle → exactly one `o_done` per accepted request.
- `sys_rst_n` low during ACCUM → all outputs 0 and `o_cal_ok`=0. After release, with no `i_start`, `o_busy` stays 0 across subsequent frames.

Source files
------------

// File: rtl/color_calib_pkg.sv
// Shared definitions for the colour calibration block: channel width,
// FSM state encoding and the width rule used for V and the saturating results.
package color_calib_pkg;

    localparam int COLOR_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_ACCUM = 2'd2,
        ST_CALC  = 2'd3
    } state_t;

    // Width of R+G+B and of the saturating err/Vmin/Vmax results.
    function automatic int sat_width(input int c_w);
        return c_w + 2;
    endfunction

endpackage

// File: rtl/color_calib_if.sv
// Pixel stream, calibration request and parameter-set outputs of color_calib.
// The master drives the pixel stream; the slave (color_calib) returns the result.
interface color_calib_if
    import color_calib_pkg::*;
#(
    parameter int C_W = COLOR_WIDTH
);
    localparam int VW = sat_width(C_W);

    logic           i_start;
    logic           i_vs;
    logic           i_valid;
    logic [C_W-1:0] i_R;
    logic [C_W-1:0] i_G;
    logic [C_W-1:0] i_B;

    logic           o_busy;
    logic           o_done;
    logic           o_cal_ok;
    logic [C_W-1:0] o_R0;
    logic [C_W-1:0] o_G0;
    logic [C_W-1:0] o_B0;
    logic [VW-1:0]  o_err;
    logic [VW-1:0]  o_Vmin;
    logic [VW-1:0]  o_Vmax;

    modport master (
        output i_start, i_vs, i_valid, i_R, i_G, i_B,
        input  o_busy, o_done, o_cal_ok, o_R0, o_G0, o_B0, o_err, o_Vmin, o_Vmax
    );

    modport slave (
        input  i_start, i_vs, i_valid, i_R, i_G, i_B,
        output o_busy, o_done, o_cal_ok, o_R0, o_G0, o_B0, o_err, o_Vmin, o_Vmax
    );

endinterface

// File: rtl/color_calib_stat.sv
// Running sum / min / max of one value stream. With HAS_SUM=0 the sum stays 0
// and only the min/max tracking is used (brightness statistics).
module color_calib_stat #(
    parameter int W       = 8,
    parameter int SUM_W   = 16,
    parameter bit HAS_SUM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [W-1:0]     din,
    output logic [SUM_W-1:0] sum,
    output logic [W-1:0]     lo,
    output logic [W-1:0]     hi
);

    // A clear coinciding with a sample restarts the statistics from that sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            lo  <= '0;
            hi  <= '0;
        end else if (clr) begin
            sum <= (HAS_SUM && en) ? SUM_W'(din) : '0;
            lo  <= en ? din : '1;
            hi  <= en ? din : '0;
        end else if (en) begin
            if (HAS_SUM) begin
                sum <= sum + SUM_W'(din);
            end
            if (din < lo) begin
                lo <= din;
            end
            if (din > hi) begin
                hi <= din;
            end
        end
    end

endmodule

// File: rtl/color_calib.sv
// ROI statistics collector producing the classifier reference set
// (channel means, colour tolerance and brightness window) once per request.
module color_calib
    import color_calib_pkg::*;
#(
    parameter int C_W        = COLOR_WIDTH,
    parameter int H_ACT      = 640,
    parameter int ROI_X      = 312,
    parameter int ROI_Y      = 232,
    parameter int ROI_LOG2   = 4,
    parameter int ERR_MARGIN = 4,
    parameter int V_MARGIN   = 8
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    color_calib_if.slave bus
);

    localparam int VW    = sat_width(C_W);
    localparam int L2    = 2 * ROI_LOG2;
    localparam int SUM_W = C_W + L2;
    localparam int SIDE  = 1 << ROI_LOG2;
    localparam int XW    = $clog2(H_ACT);
    localparam int YW    = 16;

    state_t state;
    state_t next_state;

    logic [XW-1:0] x_cnt;
    logic [XW-1:0] px;
    logic [YW-1:0] y_cnt;
    logic [YW-1:0] py;

    logic in_roi;
    logic last_pix;
    logic acc_en;
    logic stat_clr;
    logic calc;
    logic busy;

    logic [VW-1:0] v_in;

    logic [SUM_W-1:0] r_sum;
    logic [SUM_W-1:0] g_sum;
    logic [SUM_W-1:0] b_sum;
    logic [SUM_W-1:0] v_sum_unused;
    logic [C_W-1:0]   r_lo, r_hi, g_lo, g_hi, b_lo, b_hi;
    logic [VW-1:0]    v_lo, v_hi;

    logic [C_W-1:0] r_rng, g_rng, b_rng, max_rng;
    logic [VW:0]    err_ext;
    logic [VW:0]    vmax_ext;
    logic [VW-1:0]  err_sat;
    logic [VW-1:0]  vmin_sat;
    logic [VW-1:0]  vmax_sat;

    logic           done_q;
    logic           cal_ok_q;
    logic [C_W-1:0] r0_q, g0_q, b0_q;
    logic [VW-1:0]  err_q, vmin_q, vmax_q;

    // A frame-start pulse makes the current pixel (0,0) of the new frame.
    always_comb begin
        px = bus.i_vs ? '0 : x_cnt;
        py = bus.i_vs ? '0 : y_cnt;
    end

    assign in_roi = (px >= XW'(ROI_X)) && (px < XW'(ROI_X + SIDE)) &&
                    (py >= YW'(ROI_Y)) && (py < YW'(ROI_Y + SIDE));

    assign last_pix = acc_en && (px == XW'(ROI_X + SIDE - 1)) &&
                      (py == YW'(ROI_Y + SIDE - 1));

    assign v_in = VW'(bus.i_R) + VW'(bus.i_G) + VW'(bus.i_B);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (bus.i_valid) begin
            if (px == XW'(H_ACT - 1)) begin
                x_cnt <= '0;
                y_cnt <= py + 1'b1;
            end else begin
                x_cnt <= px + 1'b1;
                y_cnt <= py;
            end
        end else if (bus.i_vs) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (bus.i_start) next_state = ST_ARM;
            ST_ARM:   if (bus.i_vs)    next_state = ST_ACCUM;
            ST_ACCUM: if (last_pix)    next_state = ST_CALC;
            ST_CALC:                   next_state = ST_IDLE;
            default:                   next_state = ST_IDLE;
        endcase
    end

    // A frame start while armed or accumulating restarts the statistics.
    always_comb begin
        busy     = (state != ST_IDLE);
        calc     = (state == ST_CALC);
        stat_clr = bus.i_vs && ((state == ST_ARM) || (state == ST_ACCUM));
        acc_en   = bus.i_valid && in_roi && ((state == ST_ACCUM) || stat_clr);
    end

    color_calib_stat #(.W(C_W), .SUM_W(SUM_W), .HAS_SUM(1'b1)) u_stat_r (
        .clk(sys_clk), .rst_n(sys_rst_n), .clr(stat_clr), .en(acc_en),
        .din(bus.i_R), .sum(r_sum), .lo(r_lo), .hi(r_hi)
    );

    color_calib_stat #(.W(C_W), .SUM_W(SUM_W), .HAS_SUM(1'b1)) u_stat_g (
        .clk(sys_clk), .rst_n(sys_rst_n), .clr(stat_clr), .en(acc_en),
        .din(bus.i_G), .sum(g_sum), .lo(g_lo), .hi(g_hi)
    );

    color_calib_stat #(.W(C_W), .SUM_W(SUM_W), .HAS_SUM(1'b1)) u_stat_b (
        .clk(sys_clk), .rst_n(sys_rst_n), .clr(stat_clr), .en(acc_en),
        .din(bus.i_B), .sum(b_sum), .lo(b_lo), .hi(b_hi)
    );

    color_calib_stat #(.W(VW), .SUM_W(SUM_W), .HAS_SUM(1'b0)) u_stat_v (
        .clk(sys_clk), .rst_n(sys_rst_n), .clr(stat_clr), .en(acc_en),
        .din(v_in), .sum(v_sum_unused), .lo(v_lo), .hi(v_hi)
    );

    assign r_rng = r_hi - r_lo;
    assign g_rng = g_hi - g_lo;
    assign b_rng = b_hi - b_lo;

    always_comb begin
        max_rng = r_rng;
        if (g_rng > max_rng) max_rng = g_rng;
        if (b_rng > max_rng) max_rng = b_rng;
    end

    // One extra bit on the additions exposes overflow for saturation.
    assign err_ext  = (VW + 1)'(max_rng) + (VW + 1)'(ERR_MARGIN);
    assign vmax_ext = (VW + 1)'(v_hi) + (VW + 1)'(V_MARGIN);
    assign err_sat  = err_ext[VW]  ? {VW{1'b1}} : err_ext[VW-1:0];
    assign vmax_sat = vmax_ext[VW] ? {VW{1'b1}} : vmax_ext[VW-1:0];
    assign vmin_sat = (v_lo >= VW'(V_MARGIN)) ? (v_lo - VW'(V_MARGIN)) : '0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            done_q   <= 1'b0;
            cal_ok_q <= 1'b0;
            r0_q     <= '0;
            g0_q     <= '0;
            b0_q     <= '0;
            err_q    <= '0;
            vmin_q   <= '0;
            vmax_q   <= '0;
        end else begin
            done_q <= calc;
            if (calc) begin
                cal_ok_q <= 1'b1;
                r0_q     <= r_sum[SUM_W-1 -: C_W];
                g0_q     <= g_sum[SUM_W-1 -: C_W];
                b0_q     <= b_sum[SUM_W-1 -: C_W];
                err_q    <= err_sat;
                vmin_q   <= vmin_sat;
                vmax_q   <= vmax_sat;
            end
        end
    end

    assign bus.o_busy   = busy;
    assign bus.o_done   = done_q;
    assign bus.o_cal_ok = cal_ok_q;
    assign bus.o_R0     = r0_q;
    assign bus.o_G0     = g0_q;
    assign bus.o_B0     = b0_q;
    assign bus.o_err    = err_q;
    assign bus.o_Vmin   = vmin_q;
    assign bus.o_Vmax   = vmax_q;

endmodule

// File: tb/tb_color_calib.sv
// Directed bench for color_calib: streams small frames with a known ROI
// pattern and checks the resulting parameter set, handshake and timing.
module tb_color_calib;

    // Short lines and a near-origin ROI keep frames small; ROI size and margins stay default.
    localparam int H     = 32;
    localparam int RX    = 8;
    localparam int RY    = 4;
    localparam int SIDE  = 16;
    localparam int NPIX  = SIDE * SIDE;
    localparam int LINES = RY + SIDE + 1;

    logic sys_clk;
    logic sys_rst_n;

    color_calib_if #(.C_W(8)) bus ();

    color_calib #(
        .C_W(8), .H_ACT(H), .ROI_X(RX), .ROI_Y(RY), .ROI_LOG2(4),
        .ERR_MARGIN(4), .V_MARGIN(8)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus(bus)
    );

    int compared;
    int failed;
    int cyc;
    int done_cnt;
    int done_edge;
    int last_roi_edge;
    logic [53:0] snap;
    logic        snap_busy;
    logic        snap_ok;
    logic [53:0] live;

    assign live = {bus.o_R0, bus.o_G0, bus.o_B0, bus.o_err, bus.o_Vmin, bus.o_Vmax};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Records every cycle o_done is seen high together with the parameter set.
    always begin
        @(posedge sys_clk);
        #1;
        if (bus.o_done === 1'b1) begin
            done_cnt  = done_cnt + 1;
            done_edge = cyc;
            snap      = live;
            snap_busy = bus.o_busy;
            snap_ok   = bus.o_cal_ok;
        end
    end

    task automatic drive(input logic start, input logic vs, input logic valid,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(posedge sys_clk);
        #1;
        bus.i_start = start;
        bus.i_vs    = vs;
        bus.i_valid = valid;
        bus.i_R     = r;
        bus.i_G     = g;
        bus.i_B     = b;
    endtask

    // mode 0: uniform ROI; mode 1: R alternates 10/30 by column, G=B=0.
    // max_roi >= 0 aborts the frame after that many ROI pixels.
    // start_idx pulses i_start with that ROI pixel, or NPIX+k with the k-th pixel after the ROI.
    task automatic send_frame(input int mode, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input int max_roi, input int start_idx);
        int roi_seen;
        int since_last;
        logic st;
        logic in;
        logic [7:0] pr, pg, pb;
        roi_seen   = 0;
        since_last = -1;
        drive(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        for (int y = 0; y < LINES; y++) begin
            for (int x = 0; x < H; x++) begin
                in = (x >= RX) && (x < RX + SIDE) && (y >= RY) && (y < RY + SIDE);
                st = 1'b0;
                if (in) begin
                    roi_seen = roi_seen + 1;
                    pr = (mode == 1) ? ((x % 2 == 0) ? 8'd10 : 8'd30) : r;
                    pg = (mode == 1) ? 8'd0 : g;
                    pb = (mode == 1) ? 8'd0 : b;
                    if (roi_seen == start_idx) st = 1'b1;
                end else begin
                    pr = 8'd200;
                    pg = 8'd1;
                    pb = 8'd99;
                    if (since_last >= 0) begin
                        if (since_last + NPIX + 1 == start_idx) st = 1'b1;
                        since_last = since_last + 1;
                    end
                end
                drive(st, 1'b0, 1'b1, pr, pg, pb);
                if (in && roi_seen == NPIX) begin
                    last_roi_edge = cyc + 1;
                    since_last    = 0;
                end
                if (max_roi >= 0 && roi_seen == max_roi) return;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic request();
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        compared++;
        if (live !== 54'd0) begin
            failed++;
            $display("[TB] FAIL reset_outputs: got %h want 0", live);
        end
        compared++;
        if ({bus.o_busy, bus.o_done, bus.o_cal_ok} !== 3'b000) begin
            failed++;
            $display("[TB] FAIL reset_flags: got %b want 000", {bus.o_busy, bus.o_done, bus.o_cal_ok});
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        compared++;
        if (bus.o_busy !== 1'b0) begin
            failed++;
            $display("[TB] FAIL reset_release_busy: got %b want 0", bus.o_busy);
        end
    endtask

    task automatic test_uniform();
        int d0;
        d0 = done_cnt;
        request();
        compared++;
        if (bus.o_busy !== 1'b1) begin
            failed++;
            $display("[TB] FAIL uniform_busy_after_start: got %b want 1", bus.o_busy);
        end
        send_frame(0, 8'd20, 8'd40, 8'd10, -1, -1);
        compared++;
        if (snap !== {8'd20, 8'd40, 8'd10, 10'd4, 10'd62, 10'd78}) begin
            failed++;
            $display("[TB] FAIL uniform_params: got %h want %h", snap,
                     {8'd20, 8'd40, 8'd10, 10'd4, 10'd62, 10'd78});
        end
        compared++;
        if (done_edge !== last_roi_edge + 1) begin
            failed++;
            $display("[TB] FAIL uniform_done_latency: got edge %0d want %0d", done_edge, last_roi_edge + 1);
        end
        compared++;
        if (done_cnt - d0 !== 1) begin
            failed++;
            $display("[TB] FAIL uniform_done_cycles: got %0d want 1", done_cnt - d0);
        end
        compared++;
        if ({snap_busy, snap_ok} !== 2'b01) begin
            failed++;
            $display("[TB] FAIL uniform_busy_ok_at_done: got %b want 01", {snap_busy, snap_ok});
        end
        compared++;
        if (live !== snap) begin
            failed++;
            $display("[TB] FAIL uniform_hold: got %h want %h", live, snap);
        end
    endtask

    task automatic test_alternating();
        request();
        send_frame(1, 8'd0, 8'd0, 8'd0, -1, -1);
        compared++;
        if (snap !== {8'd20, 8'd0, 8'd0, 10'd24, 10'd2, 10'd38}) begin
            failed++;
            $display("[TB] FAIL alternating_params: got %h want %h", snap,
                     {8'd20, 8'd0, 8'd0, 10'd24, 10'd2, 10'd38});
        end
    endtask

    task automatic test_saturation();
        request();
        send_frame(0, 8'd0, 8'd0, 8'd0, -1, -1);
        compared++;
        if (snap !== {8'd0, 8'd0, 8'd0, 10'd4, 10'd0, 10'd8}) begin
            failed++;
            $display("[TB] FAIL black_params: got %h want %h", snap,
                     {8'd0, 8'd0, 8'd0, 10'd4, 10'd0, 10'd8});
        end
        request();
        send_frame(0, 8'd255, 8'd255, 8'd255, -1, -1);
        compared++;
        if (snap !== {8'd255, 8'd255, 8'd255, 10'd4, 10'd757, 10'd773}) begin
            failed++;
            $display("[TB] FAIL white_params: got %h want %h", snap,
                     {8'd255, 8'd255, 8'd255, 10'd4, 10'd757, 10'd773});
        end
    endtask

    task automatic test_vs_restart();
        int d0;
        d0 = done_cnt;
        request();
        send_frame(0, 8'd100, 8'd100, 8'd100, 100, -1);
        send_frame(0, 8'd50, 8'd50, 8'd50, -1, -1);
        compared++;
        if (snap !== {8'd50, 8'd50, 8'd50, 10'd4, 10'd142, 10'd158}) begin
            failed++;
            $display("[TB] FAIL vs_restart_params: got %h want %h", snap,
                     {8'd50, 8'd50, 8'd50, 10'd4, 10'd142, 10'd158});
        end
        compared++;
        if (done_cnt - d0 !== 1) begin
            failed++;
            $display("[TB] FAIL vs_restart_done_count: got %0d want 1", done_cnt - d0);
        end
    endtask

    task automatic test_start_ignored();
        int d0;
        d0 = done_cnt;
        request();
        send_frame(0, 8'd60, 8'd60, 8'd60, -1, 100);
        request();
        send_frame(0, 8'd60, 8'd60, 8'd60, -1, NPIX + 1);
        compared++;
        if (done_cnt - d0 !== 2 || bus.o_busy !== 1'b0) begin
            failed++;
            $display("[TB] FAIL start_ignored: got done %0d busy %b want done 2 busy 0",
                     done_cnt - d0, bus.o_busy);
        end
        request();
        send_frame(0, 8'd60, 8'd60, 8'd60, -1, NPIX + 2);
        compared++;
        if (done_cnt - d0 !== 3 || bus.o_busy !== 1'b1) begin
            failed++;
            $display("[TB] FAIL start_in_done_cycle: got done %0d busy %b want done 3 busy 1",
                     done_cnt - d0, bus.o_busy);
        end
        send_frame(0, 8'd70, 8'd70, 8'd70, -1, -1);
        compared++;
        if (done_cnt - d0 !== 4 || snap !== {8'd70, 8'd70, 8'd70, 10'd4, 10'd202, 10'd218}) begin
            failed++;
            $display("[TB] FAIL back_to_back_request: got done %0d params %h want done 4 params %h",
                     done_cnt - d0, snap, {8'd70, 8'd70, 8'd70, 10'd4, 10'd202, 10'd218});
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        request();
        send_frame(0, 8'd90, 8'd90, 8'd90, 100, -1);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        #1;
        sys_rst_n = 1'b0;
        #1;
        compared++;
        if (live !== 54'd0) begin
            failed++;
            $display("[TB] FAIL mid_reset_outputs: got %h want 0", live);
        end
        compared++;
        if ({bus.o_busy, bus.o_done, bus.o_cal_ok} !== 3'b000) begin
            failed++;
            $display("[TB] FAIL mid_reset_flags: got %b want 000", {bus.o_busy, bus.o_done, bus.o_cal_ok});
        end
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        d0 = done_cnt;
        send_frame(0, 8'd30, 8'd30, 8'd30, -1, -1);
        send_frame(0, 8'd30, 8'd30, 8'd30, -1, -1);
        compared++;
        if (bus.o_busy !== 1'b0 || done_cnt - d0 !== 0) begin
            failed++;
            $display("[TB] FAIL after_reset_idle: got busy %b done %0d want busy 0 done 0",
                     bus.o_busy, done_cnt - d0);
        end
    endtask

    initial begin
        compared      = 0;
        failed        = 0;
        cyc           = 0;
        done_cnt      = 0;
        done_edge     = -1;
        last_roi_edge = -100;
        snap          = '0;
        snap_busy     = 1'b0;
        snap_ok       = 1'b0;
        sys_rst_n     = 1'b0;
        bus.i_start   = 1'b0;
        bus.i_vs      = 1'b0;
        bus.i_valid   = 1'b0;
        bus.i_R       = 8'd0;
        bus.i_G       = 8'd0;
        bus.i_B       = 8'd0;

        test_reset();
        test_uniform();
        test_alternating();
        test_saturation();
        test_vs_restart();
        test_start_ignored();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
